// File: rtl/crossover_if.sv
// Handshake and data bundle between the crossover stage and its requester.
// The requester drives start and the parents; the stage drives the child and status.
interface crossover_if #(
  parameter int unsigned GENE_LEN   = 12,
  parameter int unsigned CHAR_WIDTH = 8
);
  localparam int unsigned GENE_W = GENE_LEN * CHAR_WIDTH;

  logic              start;
  logic [GENE_W-1:0] parent_a;
  logic [GENE_W-1:0] parent_b;
  logic [GENE_W-1:0] child_out;
  logic [3:0]        cross_point;
  logic              busy;
  logic              done;

  modport master (
    output start, parent_a, parent_b,
    input  child_out, cross_point, busy, done
  );

  modport slave (
    input  start, parent_a, parent_b,
    output child_out, cross_point, busy, done
  );
endinterface

// File: rtl/crossover_sv.sv
// GA crossover stage: builds a child gene from two latched parents, one character per cycle.
// Define CROSSOVER_UNIFORM_EN for uniform (LFSR-masked) crossover instead of single-point.
module crossover_sv #(
  parameter int unsigned GENE_LEN   = 12,
  parameter int unsigned CHAR_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  crossover_if.slave bus
);

  localparam int unsigned GENE_W   = GENE_LEN * CHAR_WIDTH;
  localparam logic [3:0]  LAST_IDX = 4'(GENE_LEN - 1);
  localparam logic [7:0]  PT_MOD   = 8'(GENE_LEN - 1);

  typedef enum logic [1:0] {IDLE, SELECT, COPY, FINISH} state_e;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [GENE_W-1:0] a_q, a_d;
  logic [GENE_W-1:0] b_q, b_d;
  logic [GENE_W-1:0] buf_q, buf_d;
  logic [GENE_W-1:0] child_q, child_d;
  logic [3:0]        cp_q, cp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              take_a_c;
`ifdef CROSSOVER_UNIFORM_EN
  logic [GENE_LEN-1:0] mask_q, mask_d;
`endif

  // Next-state and datapath; the LFSR steps only when a point/mask is drawn.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    buf_d    = buf_q;
    child_d  = child_q;
    cp_d     = cp_q;
    lfsr_d   = lfsr_q;
    done_d   = 1'b0;
    take_a_c = 1'b0;
`ifdef CROSSOVER_UNIFORM_EN
    mask_d   = mask_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.parent_a;
          b_d     = bus.parent_b;
          state_d = SELECT;
        end
      end
      SELECT: begin
`ifdef CROSSOVER_UNIFORM_EN
        mask_d = lfsr_q[GENE_LEN-1:0];
        cp_d   = 4'd0;
`else
        cp_d   = 4'(8'd1 + (lfsr_q[7:0] % PT_MOD));
`endif
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        idx_d   = 4'd0;
        state_d = COPY;
      end
      COPY: begin
`ifdef CROSSOVER_UNIFORM_EN
        take_a_c = mask_q[idx_q];
`else
        take_a_c = (idx_q < cp_q);
`endif
        buf_d[int'(idx_q)*CHAR_WIDTH +: CHAR_WIDTH] = take_a_c
            ? a_q[int'(idx_q)*CHAR_WIDTH +: CHAR_WIDTH]
            : b_q[int'(idx_q)*CHAR_WIDTH +: CHAR_WIDTH];
        if (idx_q == LAST_IDX) state_d = FINISH;
        else                   idx_d   = idx_q + 4'd1;
      end
      FINISH: begin
        child_d = buf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      buf_q   <= '0;
      child_q <= '0;
      cp_q    <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
`ifdef CROSSOVER_UNIFORM_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      buf_q   <= buf_d;
      child_q <= child_d;
      cp_q    <= cp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lfsr_q  <= lfsr_d;
`ifdef CROSSOVER_UNIFORM_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign bus.child_out   = child_q;
  assign bus.cross_point = cp_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_crossover_sv.sv
// Directed bench for crossover_sv: LFSR/crossover model feeds a scoreboard checked on done.
module tb_crossover_sv;

  localparam int unsigned GL     = 12;
  localparam int unsigned CW     = 8;
  localparam int unsigned W      = GL * CW;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          LAT    = GL + 2;  // accept edge to done edge
  localparam int          PERIOD = GL + 3;  // done-to-done with start held high

  typedef struct {
    logic [3:0]   cp;
    logic [W-1:0] child;
  } exp_t;

  logic clk;
  logic rst;
  crossover_if #(.GENE_LEN(GL), .CHAR_WIDTH(CW)) bus ();

  crossover_sv #(.GENE_LEN(GL), .CHAR_WIDTH(CW), .LFSR_SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [15:0] m_lfsr;
  int          tests;
  int          fails;

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic exp_t model(input logic [W-1:0] pa, input logic [W-1:0] pb,
                                 input logic [15:0] l);
    exp_t e;
    logic sel;
`ifdef CROSSOVER_UNIFORM_EN
    e.cp = 4'd0;
`else
    e.cp = 4'(1 + (int'(l[7:0]) % (GL - 1)));
`endif
    for (int i = 0; i < GL; i++) begin
`ifdef CROSSOVER_UNIFORM_EN
      sel = l[i];
`else
      sel = (i < int'(e.cp));
`endif
      e.child[i*CW +: CW] = sel ? pa[i*CW +: CW] : pb[i*CW +: CW];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the accept edge (start must already be high) and records the expected child.
  task automatic accept();
    sb.push_back(model(bus.parent_a, bus.parent_b, m_lfsr));
    m_lfsr = lfsr_nx(m_lfsr);
    tick();
    chk("busy_after_accept", W'(bus.busy), W'(1));
  endtask

  // Waits for done (bounded), checking latency, busy, and the scoreboard head.
  task automatic wait_done(input int exp_n, output int n);
    exp_t e;
    n = 0;
    while (n < 4 * LAT) begin
      tick();
      n++;
      if (bus.done === 1'b1) break;
      chk("busy_during_op", W'(bus.busy), W'(1));
    end
    chk("done_latency", W'(n), W'(exp_n));
    if (bus.done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("child_out", bus.child_out, e.child);
      chk("cross_point", W'(bus.cross_point), W'(e.cp));
      chk("busy_at_done", W'(bus.busy), W'(0));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    m_lfsr = SEED;
  endtask

  logic [W-1:0] pa_all41, pb_all42, pa_r, pb_r, exp_vec;
  int           n, extra;
  time          t1, t2;

  initial begin
    tests = 0;
    fails = 0;
    bus.start = 1'b0;
    pa_all41 = {GL{8'h41}};
    pb_all42 = {GL{8'h42}};
    bus.parent_a = pa_all41;
    bus.parent_b = pb_all42;
    do_reset();

    chk("rst_child", bus.child_out, '0);
    chk("rst_cp", W'(bus.cross_point), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));

    // Op 1: first draw after reset.
    bus.start = 1'b1;
    accept();
    bus.start = 1'b0;
    wait_done(LAT, n);
`ifdef CROSSOVER_UNIFORM_EN
    for (int i = 0; i < GL; i++)
      exp_vec[i*CW +: CW] = (i inside {0, 5, 6, 7, 10, 11}) ? 8'h41 : 8'h42;
    chk("op1_cp_const", W'(bus.cross_point), W'(0));
`else
    for (int i = 0; i < GL; i++) exp_vec[i*CW +: CW] = (i < 6) ? 8'h41 : 8'h42;
    chk("op1_cp_const", W'(bus.cross_point), W'(6));
`endif
    chk("op1_child_const", bus.child_out, exp_vec);

    // Op 2: start raised during the done cycle.
    bus.start = 1'b1;
    accept();
    bus.start = 1'b0;
    chk("done_one_cycle", W'(bus.done), W'(0));
    wait_done(LAT, n);
`ifndef CROSSOVER_UNIFORM_EN
    for (int i = 0; i < GL; i++) exp_vec[i*CW +: CW] = (i < 9) ? 8'h41 : 8'h42;
    chk("op2_cp_const", W'(bus.cross_point), W'(9));
    chk("op2_child_const", bus.child_out, exp_vec);
`endif
    tick();
    chk("child_holds", bus.child_out, sb.size() == 0 ? bus.child_out : '0);

    // Op 3: distinct parents, second start and parent change mid-op are ignored.
    for (int i = 0; i < GL; i++) begin
      pa_r[i*CW +: CW] = 8'(8'h60 + i);
      pb_r[i*CW +: CW] = 8'(8'hA0 + i);
    end
    bus.parent_a = pa_r;
    bus.parent_b = pb_r;
    bus.start = 1'b1;
    accept();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start = 1'b1;
    bus.parent_a = ~pa_r;
    bus.parent_b = ~pb_r;
    tick();
    bus.start = 1'b0;
    wait_done(LAT - 5, n);
    extra = 0;
    repeat (LAT + 4) begin
      tick();
      if (bus.done === 1'b1) extra++;
    end
    chk("single_done", W'(extra), W'(0));

    // Op 4: reset at COPY idx=4 aborts and reseeds.
    bus.parent_a = pa_all41;
    bus.parent_b = pb_all42;
    bus.start = 1'b1;
    accept();
    bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    m_lfsr = SEED;
    chk("abort_child", bus.child_out, '0);
    chk("abort_done", W'(bus.done), W'(0));
    chk("abort_busy", W'(bus.busy), W'(0));
    extra = 0;
    repeat (LAT) begin
      tick();
      if (bus.done === 1'b1) extra++;
    end
    chk("abort_no_done", W'(extra), W'(0));
    bus.start = 1'b1;
    accept();
    bus.start = 1'b0;
    wait_done(LAT, n);
`ifndef CROSSOVER_UNIFORM_EN
    chk("reseed_cp", W'(bus.cross_point), W'(6));
`endif

    // Op 5: start held high across three operations.
    do_reset();
    bus.start = 1'b1;
    accept();
    wait_done(LAT, n);
    t1 = $time;
    accept();
    wait_done(LAT, n);
    t2 = $time;
    chk("period_1", W'((t2 - t1) / 10), W'(PERIOD));
`ifndef CROSSOVER_UNIFORM_EN
    chk("held_cp2", W'(bus.cross_point), W'(9));
`endif
    t1 = t2;
    accept();
    bus.start = 1'b0;
    wait_done(LAT, n);
    t2 = $time;
    chk("period_2", W'((t2 - t1) / 10), W'(PERIOD));
    chk("sb_drained", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
